// File: rtl/sk6812_pkg.sv
// Shared definitions for the SK6812RGBW frame scheduler.
//   state_e            : frame scheduler states (IDLE, RUN, DRAIN)
//   CLOCK_CYCLE_COUNT  : clock cycles per 800 kHz bit slot
//   DRAIN_CYCLES       : cycles to wait after the last request
//                        (32 bits of the last LED + 600 bit-slot latch + 4 margin)
//   LANE_R..LANE_W     : byte-lane indices inside an RGBW word
package sk6812_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_e;

  localparam int LANE_R = 0;
  localparam int LANE_G = 1;
  localparam int LANE_B = 2;
  localparam int LANE_W = 3;

  function automatic int CLOCK_CYCLE_COUNT(input int clock_frq);
    return clock_frq / 800_000;
  endfunction

  function automatic int DRAIN_CYCLES(input int clock_frq);
    return (32 + 600 + 4) * CLOCK_CYCLE_COUNT(clock_frq);
  endfunction

endpackage

// File: rtl/sk6812_frame_ram.sv
// Double-buffered frame store: 2*LEDS_NUM words of 32 bits.
//   clock   : rising-edge clock
//   wr_en   : synchronous write strobe
//   wr_addr : {bank, led index}
//   wr_data : RGBW word to store
//   rd_en   : synchronous read strobe
//   rd_addr : {bank, led index}
//   rd_data : registered read data, held while rd_en is low
// The bank select is the address MSB; bank 1 is packed directly after
// bank 0 so the storage is exactly 2*LEDS_NUM deep. Callers only issue
// accesses with led index < LEDS_NUM.
module sk6812_frame_ram #(
  parameter int LEDS_NUM = 3,
  parameter int IDX_W    = 2
) (
  input  logic             clock,
  input  logic             wr_en,
  input  logic [IDX_W:0]   wr_addr,
  input  logic [31:0]      wr_data,
  input  logic             rd_en,
  input  logic [IDX_W:0]   rd_addr,
  output logic [31:0]      rd_data
);

  localparam int DEPTH  = 2 * LEDS_NUM;
  localparam int MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [31:0] mem [DEPTH];

  function automatic logic [MEM_AW-1:0] lin_addr(input logic [IDX_W:0] a);
    return MEM_AW'((a[IDX_W] ? LEDS_NUM : 0) + int'(a[IDX_W-1:0]));
  endfunction

  always_ff @(posedge clock) begin
    if (wr_en) mem[lin_addr(wr_addr)] <= wr_data;
    if (rd_en) rd_data <= mem[lin_addr(rd_addr)];
  end

endmodule

// File: rtl/sk6812_frame_scheduler.sv
// Frame-level controller for an SK6812RGBW serial LED driver.
//   clock, reset_n        : clock and asynchronous active-low reset
//   wr_en/wr_addr/wr_data : host writes into the back bank
//   commit                : request a bank swap at the next frame start
//   brightness            : global scale, latched at frame start
//   commit_ack            : pulse in the first RUN cycle of a swapping frame
//   busy                  : high from frame start until the drain completes
//   frame_done            : pulse when the drain completes
//   drv_reset             : holds the driver in reset while IDLE
//   drv_new_data_req      : driver request (rising edge is served)
//   drv_current_ledN      : LED index requested by the driver
//   drv_color_rgbw        : scaled colour word, valid 2 cycles after request
module sk6812_frame_scheduler
  import sk6812_pkg::*;
#(
  parameter int LEDS_NUM       = 3,
  parameter int CLOCK_FRQ      = 50_000_000,
  parameter int REFRESH_HZ     = 100,
  parameter int LED_ADDR_WIDTH = $clog2(LEDS_NUM + 1)
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic                      wr_en,
  input  logic [LED_ADDR_WIDTH-1:0] wr_addr,
  input  logic [31:0]               wr_data,
  input  logic                      commit,
  input  logic [7:0]                brightness,
  output logic                      commit_ack,
  output logic                      busy,
  output logic                      frame_done,
  output logic                      drv_reset,
  input  logic                      drv_new_data_req,
  input  logic [LED_ADDR_WIDTH-1:0] drv_current_ledN,
  output logic [31:0]               drv_color_rgbw
);

  localparam int DRAIN_N        = DRAIN_CYCLES(CLOCK_FRQ);
  localparam int DRAIN_W        = $clog2(DRAIN_N + 1);
  localparam int REFRESH_PERIOD = (REFRESH_HZ == 0) ? 1 : CLOCK_FRQ / REFRESH_HZ;
  localparam int REF_W          = $clog2(REFRESH_PERIOD + 1);

  // Per-lane scale: (c * (bri + 1)) >> 8, keeping the upper byte of the
  // 16-bit product so bri=255 is an exact pass-through.
  function automatic logic [31:0] scale_rgbw(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = '0;
    for (int i = LANE_R; i <= LANE_W; i++)
      r[8*i +: 8] = 8'((16'(c[8*i +: 8]) * (16'(b) + 16'd1)) >> 8);
    return r;
  endfunction

  state_e               state, state_nxt;
  logic                 front_bank;
  logic                 commit_pend;
  logic [REF_W-1:0]     refresh_cnt;
  logic [DRAIN_W-1:0]   drain_cnt;
  logic [7:0]           bri_q;
  logic                 refresh_exp;
  logic                 start, swap, done;
  logic                 req_q, req_rise, rd_oob, last_req;
  logic                 wr_ok;
  logic                 vld_p0, oob_p0;
  logic [31:0]          ram_q_p0;

  assign refresh_exp = (REFRESH_HZ != 0) && (refresh_cnt == REF_W'(REFRESH_PERIOD - 1));
  assign req_rise    = drv_new_data_req && !req_q && (state == RUN);
  assign rd_oob      = int'(drv_current_ledN) >= LEDS_NUM;
  assign last_req    = rd_oob;
  assign wr_ok       = wr_en && (int'(wr_addr) < LEDS_NUM);
  assign busy        = (state != IDLE);
  assign drv_reset   = (state == IDLE);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    swap      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        // A commit arriving this cycle counts as pending, so a write and a
        // commit in the same cycle land in the bank that becomes the front.
        if (commit_pend || commit || refresh_exp) begin
          state_nxt = RUN;
          start     = 1'b1;
          swap      = commit_pend || commit;
        end
      end
      RUN: begin
        if (req_rise && last_req) state_nxt = DRAIN;
      end
      DRAIN: begin
        if (drain_cnt == DRAIN_W'(DRAIN_N - 1)) begin
          state_nxt = IDLE;
          done      = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      front_bank  <= 1'b0;
      commit_pend <= 1'b0;
      refresh_cnt <= '0;
      drain_cnt   <= '0;
      commit_ack  <= 1'b0;
      frame_done  <= 1'b0;
    end else begin
      commit_ack <= swap;
      frame_done <= done;
      if (swap)        front_bank <= ~front_bank;
      if (start)       commit_pend <= 1'b0;
      else if (commit) commit_pend <= 1'b1;
      if (start)                            refresh_cnt <= '0;
      else if (REFRESH_HZ != 0 && !refresh_exp) refresh_cnt <= refresh_cnt + REF_W'(1);
      if (state != DRAIN) drain_cnt <= '0;
      else                drain_cnt <= drain_cnt + DRAIN_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (start) bri_q <= brightness;
  end

  sk6812_frame_ram #(
    .LEDS_NUM (LEDS_NUM),
    .IDX_W    (LED_ADDR_WIDTH)
  ) u_ram (
    .clock   (clock),
    .wr_en   (wr_ok),
    .wr_addr ({~front_bank, wr_addr}),
    .wr_data (wr_data),
    .rd_en   (req_rise && !rd_oob),
    .rd_addr ({front_bank, drv_current_ledN}),
    .rd_data (ram_q_p0)
  );

  // ---- stage p0: request edge launches the RAM read ----
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      req_q  <= 1'b0;
      vld_p0 <= 1'b0;
      oob_p0 <= 1'b0;
    end else begin
      req_q  <= drv_new_data_req;
      vld_p0 <= req_rise;
      if (req_rise) oob_p0 <= rd_oob;
    end
  end

  // ---- stage p1: brightness scale into the output register ----
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)    drv_color_rgbw <= '0;
    else if (vld_p0) drv_color_rgbw <= oob_p0 ? '0 : scale_rgbw(ram_q_p0, bri_q);
  end

endmodule

// File: doc/sk6812_frame_scheduler.md
# sk6812_frame_scheduler

Frame-level controller for the SK6812RGBW serial LED driver. Holds a double-buffered RGBW frame, answers the driver's per-LED data requests with brightness-scaled colour words, and decides when each frame is transmitted. A frame starts on a host commit or on an auto-refresh tick. Between frames the driver is held in reset.

## Interface
- `LEDS_NUM`, 3: LEDs in the chain.
- `CLOCK_FRQ`, 50_000_000: clock frequency in Hz.
- `REFRESH_HZ`, 100: auto-refresh rate. A value of 0 disables auto-refresh.
- `LED_ADDR_WIDTH`, derived: `$clog2(LEDS_NUM+1)`. The driver indexes LEDs 0..LEDS_NUM.

- `clock`  in  1  sole clock, rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `wr_en`  in  1  host write strobe for the back bank.
- `wr_addr`  in  LED_ADDR_WIDTH  LED index to write.
- `wr_data`  in  32  RGBW word: [7:0] R, [15:8] G, [23:16] B, [31:24] W.
- `commit`  in  1  one-cycle pulse requesting a bank swap.
- `brightness`  in  8  global scale factor, sampled once at frame start.
- `commit_ack`  out  1  one-cycle pulse when the swap takes effect.
- `busy`  out  1  high from frame start until the drain completes.
- `frame_done`  out  1  one-cycle pulse when the drain completes.
- `drv_reset`  out  1  active-high reset to the driver.
- `drv_new_data_req`  in  1  request from the driver.
- `drv_current_ledN`  in  LED_ADDR_WIDTH  LED index the driver is requesting.
- `drv_color_rgbw`  out  32  colour word presented to the driver.

## Operation
- Reset values:
  - drv_reset=1, drv_color_rgbw=0.
  - commit_ack=0, busy=0, frame_done=0.
  - front bank = 0, commit pending cleared, refresh timer = 0, state IDLE.
  - RAM contents are not reset.
- Host writes:
  - Writes always target the back bank.
  - A write with wr_addr >= LEDS_NUM is ignored.
  - A swap does not copy data. The new back bank holds the previous frame, so the host rewrites any LEDs it wants changed.
- Commit:
  - `commit` sets a pending flag. Further commits while pending merge into the same flag.
  - The swap happens only on the IDLE→RUN transition, never mid-frame.
- State machine:
  - IDLE: drv_reset=1. Moves to RUN when the commit flag is pending or the refresh timer has expired. On that transition:
    - swap banks (if pending) and pulse commit_ack;
    - latch brightness into `bri_q`;
    - clear the refresh timer;
    - set busy.
  - RUN: drv_reset=0. On each rising edge of drv_new_data_req, read the front bank at drv_current_ledN. Any index >= LEDS_NUM reads as 0 (covers the driver's extra trailing LED). After the request for index LEDS_NUM has been served, go to DRAIN.
  - DRAIN: count DRAIN_CYCLES = (32+600+4)·(CLOCK_FRQ/800_000). This covers the last LED plus the latch low time. Then:
    - pulse frame_done;
    - clear busy;
    - assert drv_reset;
    - go to IDLE.
- Brightness scaling, applied per byte lane: out = (c·(bri_q+1))>>8.
  - The product is 16 bits and the upper byte is kept.
  - bri_q=255 passes data unchanged. bri_q=0 gives c>>8, which is 0.
- Refresh timer:
  - Counts up to CLOCK_FRQ/REFRESH_HZ − 1 and then saturates as "expired".
  - Cleared at frame start.
  - Never expires when REFRESH_HZ=0.

## Timing
- Request to data: drv_color_rgbw is valid 2 cycles after the drv_new_data_req rising edge (RAM read, then scale register). The driver's prepare delay must be ≥ 3 cycles.
- drv_color_rgbw holds its value until the next request is served.
- commit_ack, busy rise and drv_reset fall occur in the same cycle: the first RUN cycle.
- A write and a commit in the same cycle: the write lands in the old back bank before the swap, so it is visible in the next frame.
- A commit during RUN or DRAIN is acknowledged at the next frame start, one IDLE cycle after frame_done.
- A commit and refresh expiry together start a single frame, with the swap.
- reset_n asserted mid-frame: all outputs return to their reset values immediately and the driver is held in reset. Nothing is pending after release.

## Structure
- Shared package `sk6812_pkg`:
  - state enum (IDLE, RUN, DRAIN);
  - `CLOCK_CYCLE_COUNT` function of CLOCK_FRQ;
  - `DRAIN_CYCLES`;
  - byte-lane index constants R/G/B/W.
- Sub-module `sk6812_frame_ram`: 2·LEDS_NUM×32 storage with one synchronous write port and one synchronous read port. The bank select is the MSB of the address.

## Test plan
- After reset, with REFRESH_HZ=0 and no commit: drv_reset stays 1 and drv_color_rgbw=0 for 10 000 cycles.
- Write LED0=0x11223344, LED1=0xFFFFFFFF, LED2=0x00000080, then commit with brightness=255 → commit_ack pulse, then the driver model receives exactly those words plus 0 for index 3, followed by frame_done.
- Same frame with brightness=127 → LED1 reads 0x7F7F7F7F and LED2 reads 0x00000040.
- Commit pulsed mid-RUN, with new data written to the back bank → the current frame still shows the old data, and commit_ack comes 1 cycle after frame_done with the new data in the next frame.
- REFRESH_HZ=1000 at 50 MHz with no commits → frames start every 50 000 cycles and commit_ack never pulses.
- reset_n pulsed low during DRAIN → drv_reset=1, busy=0 asynchronously, and no frame starts until a commit.
